// File: rtl/sram_arb_pkg.sv
// Shared types and constants for the two-port asynchronous SRAM arbiter.
// Holds the FSM state encoding, the owner encoding, bus widths and a helper
// that maps each state to the SRAM strobe pattern it drives.
package sram_arb_pkg;

  localparam int ADDR_W = 20;
  localparam int DATA_W = 16;

  typedef enum logic [2:0] {
    IDLE,
    RD_1,
    RD_2,
    WR_1,
    WR_2,
    WR_3,
    ACK
  } state_t;

  typedef enum logic {
    OWN_CPU,
    OWN_LDR
  } owner_t;

  // Active-low SRAM strobes grouped so they can be registered together.
  typedef struct packed {
    logic ce;
    logic ub;
    logic lb;
    logic oe;
    logic we;
  } strobe_t;

  // Strobe pattern to be presented while the FSM sits in state s.
  function automatic strobe_t strobes_for(input state_t s);
    strobe_t st;
    st = '{default: 1'b1};
    case (s)
      RD_1, RD_2: begin
        st.ce = 1'b0;
        st.ub = 1'b0;
        st.lb = 1'b0;
        st.oe = 1'b0;
      end
      WR_1, WR_2, WR_3: begin
        st.ce = 1'b0;
        st.ub = 1'b0;
        st.lb = 1'b0;
        st.we = 1'b0;
      end
      default: ;
    endcase
    return st;
  endfunction

endpackage

// File: rtl/sram_arbiter.sv
// Two-requester (CPU, loader) arbiter in front of a 16-bit asynchronous SRAM.
// A read takes RD_1/RD_2 then ACK; a write takes WR_1..WR_3 then ACK.
// All SRAM-side outputs and acks are registered: each transition loads the
// values belonging to the state being entered.
// Build option: define SRAM_ARB_ROUND_ROBIN_EN to alternate grants on
// simultaneous requests; otherwise the CPU has fixed priority.
module sram_arbiter
  import sram_arb_pkg::*;
(
  input  logic              Clk,
  input  logic              Reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  input  logic              ldr_req,
  input  logic              ldr_we,
  input  logic [ADDR_W-1:0] ldr_addr,
  input  logic [DATA_W-1:0] ldr_wdata,
  output logic              ldr_ack,
  output logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_dq_out,
  output logic              sram_dq_oe,
  input  logic [DATA_W-1:0] sram_dq_in,
  output logic              Mem_CE,
  output logic              Mem_UB,
  output logic              Mem_LB,
  output logic              Mem_OE,
  output logic              Mem_WE
);

  state_t            state;
  owner_t            owner;
  strobe_t           strb;

  logic              grant_valid;
  owner_t            grant_owner;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  assign Mem_CE = strb.ce;
  assign Mem_UB = strb.ub;
  assign Mem_LB = strb.lb;
  assign Mem_OE = strb.oe;
  assign Mem_WE = strb.we;

  // Arbitration: pick the requester to serve and select its request fields.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no path can infer a latch.
    grant_valid = cpu_req | ldr_req;
    grant_owner = OWN_LDR;
    if (cpu_req && ldr_req) begin
`ifdef SRAM_ARB_ROUND_ROBIN_EN
      grant_owner = (owner == OWN_CPU) ? OWN_LDR : OWN_CPU;
`else
      grant_owner = OWN_CPU;
`endif
    end else if (cpu_req) begin
      grant_owner = OWN_CPU;
    end
    sel_we    = (grant_owner == OWN_CPU) ? cpu_we    : ldr_we;
    sel_addr  = (grant_owner == OWN_CPU) ? cpu_addr  : ldr_addr;
    sel_wdata = (grant_owner == OWN_CPU) ? cpu_wdata : ldr_wdata;
  end

  // Access FSM with registered SRAM strobes, bus control, read data and acks.
  always_ff @(posedge Clk) begin
    // NOTE: all state here uses non-blocking assignments so every register samples pre-edge values.
    if (Reset) begin
      state       <= IDLE;
      owner       <= OWN_LDR;
      strb        <= strobes_for(IDLE);
      rdata       <= '0;
      sram_addr   <= '0;
      sram_dq_out <= '0;
      sram_dq_oe  <= 1'b0;
      cpu_ack     <= 1'b0;
      ldr_ack     <= 1'b0;
    end else begin
      cpu_ack <= 1'b0;
      ldr_ack <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_valid) begin
            owner     <= grant_owner;
            sram_addr <= sel_addr;
            if (sel_we) begin
              state       <= WR_1;
              strb        <= strobes_for(WR_1);
              sram_dq_out <= sel_wdata;
              sram_dq_oe  <= 1'b1;
            end else begin
              state <= RD_1;
              strb  <= strobes_for(RD_1);
            end
          end
        end
        RD_1: begin
          state <= RD_2;
          strb  <= strobes_for(RD_2);
        end
        RD_2: begin
          state   <= ACK;
          strb    <= strobes_for(ACK);
          rdata   <= sram_dq_in;
          cpu_ack <= (owner == OWN_CPU);
          ldr_ack <= (owner == OWN_LDR);
        end
        WR_1: begin
          state <= WR_2;
          strb  <= strobes_for(WR_2);
        end
        WR_2: begin
          state <= WR_3;
          strb  <= strobes_for(WR_3);
        end
        WR_3: begin
          state       <= ACK;
          strb        <= strobes_for(ACK);
          sram_dq_oe  <= 1'b0;
          sram_dq_out <= '0;
          cpu_ack     <= (owner == OWN_CPU);
          ldr_ack     <= (owner == OWN_LDR);
        end
        ACK: begin
          state <= IDLE;
          strb  <= strobes_for(IDLE);
        end
        default: begin
          state <= IDLE;
          strb  <= strobes_for(IDLE);
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// Self-checking bench for sram_arbiter: directed scenarios followed by
// randomized traffic on both ports, compared every cycle against a
// transaction-level model (current transaction + cycle index within it).
// Build option: SRAM_ARB_ROUND_ROBIN_EN selects the alternating-grant model.
module tb_sram_arbiter;

  logic        Clk;
  logic        Reset;
  logic        cpu_req, cpu_we;
  logic [19:0] cpu_addr;
  logic [15:0] cpu_wdata;
  logic        cpu_ack;
  logic        ldr_req, ldr_we;
  logic [19:0] ldr_addr;
  logic [15:0] ldr_wdata;
  logic        ldr_ack;
  logic [15:0] rdata;
  logic [19:0] sram_addr;
  logic [15:0] sram_dq_out;
  logic        sram_dq_oe;
  logic [15:0] sram_dq_in;
  logic        Mem_CE, Mem_UB, Mem_LB, Mem_OE, Mem_WE;

  sram_arbiter dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .cpu_req    (cpu_req),
    .cpu_we     (cpu_we),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_ack    (cpu_ack),
    .ldr_req    (ldr_req),
    .ldr_we     (ldr_we),
    .ldr_addr   (ldr_addr),
    .ldr_wdata  (ldr_wdata),
    .ldr_ack    (ldr_ack),
    .rdata      (rdata),
    .sram_addr  (sram_addr),
    .sram_dq_out(sram_dq_out),
    .sram_dq_oe (sram_dq_oe),
    .sram_dq_in (sram_dq_in),
    .Mem_CE     (Mem_CE),
    .Mem_UB     (Mem_UB),
    .Mem_LB     (Mem_LB),
    .Mem_OE     (Mem_OE),
    .Mem_WE     (Mem_WE)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  int n_checks = 0;
  int n_errors = 0;
  int n_cpu_ack = 0;
  int n_ldr_ack = 0;

  // Reference model: one transaction in flight, m_phase counts cycles since grant.
  bit          m_busy;
  int          m_phase;
  bit          m_we;
  bit          m_own_cpu;   // also the last-owner memory used by round robin
  logic [19:0] m_addr;
  logic [15:0] m_wdata;
  logic [15:0] m_rdata;
  bit          m_fresh;     // no grant since the last reset

  bit cpu_pend, ldr_pend;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Read completes 3 cycles after grant, write 4 cycles after grant.
  function automatic int ack_ph();
    return m_we ? 4 : 3;
  endfunction

  function automatic bit m_ack_now();
    return m_busy && (m_phase == ack_ph());
  endfunction

  task automatic check_all();
    bit acc, rd, wr, ackn;
    acc  = m_busy && (m_phase < ack_ph());
    rd   = acc && !m_we;
    wr   = acc && m_we;
    ackn = m_ack_now();
    check("Mem_CE",  32'(Mem_CE), 32'(!acc));
    check("Mem_UB",  32'(Mem_UB), 32'(!acc));
    check("Mem_LB",  32'(Mem_LB), 32'(!acc));
    check("Mem_OE",  32'(Mem_OE), 32'(!rd));
    check("Mem_WE",  32'(Mem_WE), 32'(!wr));
    check("dq_oe",   32'(sram_dq_oe), 32'(wr));
    check("cpu_ack", 32'(cpu_ack), 32'(ackn && m_own_cpu));
    check("ldr_ack", 32'(ldr_ack), 32'(ackn && !m_own_cpu));
    check("rdata",   32'(rdata), 32'(m_rdata));
    if (acc || m_fresh) check("sram_addr", 32'(sram_addr), 32'(m_addr));
    if (wr) check("dq_out", 32'(sram_dq_out), 32'(m_wdata));
    if (m_fresh) check("dq_out_rst", 32'(sram_dq_out), 32'h0);
  endtask

  // Apply the rules for the coming rising edge using the currently driven inputs.
  task automatic advance();
    bit g_cpu;
    if (Reset) begin
      m_busy    = 1'b0;
      m_own_cpu = 1'b0;
      m_rdata   = '0;
      m_addr    = '0;
      m_fresh   = 1'b1;
    end else if (m_busy) begin
      if (!m_we && m_phase == 2) m_rdata = sram_dq_in;
      if (m_phase == ack_ph()) m_busy = 1'b0;
      else m_phase++;
    end else if (cpu_req || ldr_req) begin
      if (cpu_req && ldr_req) begin
`ifdef SRAM_ARB_ROUND_ROBIN_EN
        g_cpu = !m_own_cpu;
`else
        g_cpu = 1'b1;
`endif
      end else begin
        g_cpu = cpu_req;
      end
      m_own_cpu = g_cpu;
      m_busy    = 1'b1;
      m_phase   = 1;
      m_we      = g_cpu ? cpu_we    : ldr_we;
      m_addr    = g_cpu ? cpu_addr  : ldr_addr;
      m_wdata   = g_cpu ? cpu_wdata : ldr_wdata;
      m_fresh   = 1'b0;
    end
  endtask

  // Check this cycle, step the model, move to the next sampling point.
  task automatic tick();
    check_all();
    if (cpu_ack === 1'b1) n_cpu_ack++;
    if (ldr_ack === 1'b1) n_ldr_ack++;
    advance();
    @(negedge Clk);
  endtask

  task automatic drive_random();
    bit ackn;
    ackn = m_ack_now();
    if (ackn && m_own_cpu)  cpu_pend = 1'b0;
    if (ackn && !m_own_cpu) ldr_pend = 1'b0;
    if (!cpu_pend && $urandom_range(0, 2) == 0) begin
      cpu_pend  = 1'b1;
      cpu_we    = 1'($urandom);
      cpu_addr  = 20'($urandom);
      cpu_wdata = 16'($urandom);
    end
    if (!ldr_pend && $urandom_range(0, 2) == 0) begin
      ldr_pend  = 1'b1;
      ldr_we    = 1'($urandom);
      ldr_addr  = 20'($urandom);
      ldr_wdata = 16'($urandom);
    end
    // Fields of a request already latched may wander without effect.
    if (m_busy && !ackn && $urandom_range(0, 1) == 0) begin
      if (m_own_cpu) begin
        cpu_we = 1'($urandom); cpu_addr = 20'($urandom); cpu_wdata = 16'($urandom);
      end else begin
        ldr_we = 1'($urandom); ldr_addr = 20'($urandom); ldr_wdata = 16'($urandom);
      end
    end
    cpu_req    = cpu_pend;
    ldr_req    = ldr_pend;
    sram_dq_in = 16'($urandom);
    Reset      = ($urandom_range(0, 59) == 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int c0, l0;
    Reset = 1'b1;
    cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
    ldr_req = 0; ldr_we = 0; ldr_addr = '0; ldr_wdata = '0;
    sram_dq_in = '0;
    cpu_pend = 0; ldr_pend = 0;
    m_phase = 0; m_we = 0; m_wdata = '0;
    advance();
    @(negedge Clk);
    Reset = 1'b0;

    // CPU read of 0x00010, address wanders to 0x00055 during RD_1.
    cpu_req = 1; cpu_we = 0; cpu_addr = 20'h00010; sram_dq_in = 16'hBEEF;
    tick();                                 // cycle 0: grant
    cpu_addr = 20'h00055;
    check("d1_oe_c1", 32'(Mem_OE), 32'h0);
    tick();                                 // cycle 1
    check("d1_addr_c2", 32'(sram_addr), 32'h00010);
    check("d1_oe_c2", 32'(Mem_OE), 32'h0);
    tick();                                 // cycle 2
    check("d1_cpu_ack", 32'(cpu_ack), 32'h1);
    check("d1_ldr_ack", 32'(ldr_ack), 32'h0);
    check("d1_rdata", 32'(rdata), 32'hBEEF);
    cpu_req = 0;
    tick();                                 // cycle 3: ACK
    tick();

    // Loader write of 0x1234 to 0x00020.
    ldr_req = 1; ldr_we = 1; ldr_addr = 20'h00020; ldr_wdata = 16'h1234;
    tick();
    for (int i = 1; i <= 3; i++) begin
      check("d2_we", 32'(Mem_WE), 32'h0);
      check("d2_dq_oe", 32'(sram_dq_oe), 32'h1);
      check("d2_dq_out", 32'(sram_dq_out), 32'h1234);
      check("d2_ldr_ack_early", 32'(ldr_ack), 32'h0);
      tick();
    end
    check("d2_ldr_ack", 32'(ldr_ack), 32'h1);
    check("d2_cpu_ack", 32'(cpu_ack), 32'h0);
    ldr_req = 0;
    tick();
    tick();

    // Reset during WR_2 aborts the write with no ack.
    l0 = n_ldr_ack;
    ldr_req = 1; ldr_we = 1; ldr_addr = 20'h00030; ldr_wdata = 16'h5555;
    tick();                                 // cycle 0
    tick();                                 // cycle 1: WR_1
    check("d3_we_wr2", 32'(Mem_WE), 32'h0);
    Reset = 1; ldr_req = 0;
    tick();                                 // cycle 2: WR_2, reset sampled
    Reset = 0;
    check("d3_we_after_rst", 32'(Mem_WE), 32'h1);
    check("d3_ce_after_rst", 32'(Mem_CE), 32'h1);
    for (int i = 0; i < 6; i++) tick();
    check("d3_no_ack", 32'(n_ldr_ack), 32'(l0));

    // Both ports reading continuously from a fresh reset.
    Reset = 1;
    tick();
    Reset = 0;
    cpu_req = 1; cpu_we = 0; cpu_addr = 20'h00100;
    ldr_req = 1; ldr_we = 0; ldr_addr = 20'h00200;
    c0 = n_cpu_ack; l0 = n_ldr_ack;
    for (int i = 0; i < 40; i++) begin
      sram_dq_in = 16'($urandom);
      tick();
    end
`ifdef SRAM_ARB_ROUND_ROBIN_EN
    check("d4_cpu_grants", 32'(n_cpu_ack - c0), 32'd5);
    check("d4_ldr_grants", 32'(n_ldr_ack - l0), 32'd5);
`else
    check("d4_cpu_grants", 32'(n_cpu_ack - c0), 32'd10);
    check("d4_ldr_grants", 32'(n_ldr_ack - l0), 32'd0);
`endif
    cpu_req = 0; ldr_req = 0;
    Reset = 1;
    tick();
    Reset = 0;

    // Randomized traffic on both ports with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      drive_random();
      tick();
    end
    Reset = 0; cpu_req = 0; ldr_req = 0;
    for (int i = 0; i < 6; i++) tick();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
